freq_lock_ctrl: RTL and testbench

Sequencer for the ring-oscillator frequency-ratio counter in the ADPLL.
- Runs a measurement window on the counter: enable, reset pulse, wait, then capture C_freq.
- Performs an MSB-first binary (SAR) search of the DCO control code against a target count.
- Then moves to continuous ±1 tracking with lock detection.
- Sits between the frequency-ratio counter and the DCO code input, in the F_clk (reference) domain.

---
 rtl/adpll_pkg.sv | 18 +
 rtl/freq_lock_ctrl_win_timer.sv | 36 +++
 rtl/freq_lock_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_freq_lock_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/adpll_pkg.sv
// Shared types and constants for the ADPLL frequency-lock sequencer.
// Imported by the controller and its window timer.
package adpll_pkg;

  localparam int CNT_W          = 32;
  localparam int DEF_WIN_CYC    = 102;
  localparam int DEF_SETTLE_CYC = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MRST,
    MEASURE,
    SAR_EVAL,
    TRK_EVAL
  } fsm_state_t;

endpackage

// File: rtl/freq_lock_ctrl_win_timer.sv
// Loadable down-counter that pulses done on its last counted cycle.
// Shared by the settle wait and the measurement window.
module win_timer #(
  parameter int W = 16
) (
  input  logic         F_clk,
  input  logic         combReset,
  input  logic         ld_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // next count: load wins, otherwise count down to zero and stop
  always_comb begin
    cnt_d = cnt_q;
    if (ld_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // counter register
  always_ff @(posedge F_clk or posedge combReset) begin
    if (combReset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/freq_lock_ctrl.sv
// DCO code sequencer: windowed measurement, SAR acquisition,
// then +/-1 tracking with lock detection.
module freq_lock_ctrl
  import adpll_pkg::*;
#(
  parameter int          CODE_W     = 8,
  parameter int          WIN_CYC    = DEF_WIN_CYC,
  parameter int          SETTLE_CYC = DEF_SETTLE_CYC,
  parameter logic [15:0] TOL        = 16'd8,
  parameter int          LOCK_CNT   = 4
) (
  input  logic              F_clk,
  input  logic              combReset,
  input  logic              start,
  input  logic [CNT_W-1:0]  target,
  input  logic [CNT_W-1:0]  c_freq,
  output logic              meas_en,
  output logic              meas_reset,
  output logic [CODE_W-1:0] dco_code,
  output logic              sar_done,
  output logic              locked,
  output logic              sat,
  output logic [CNT_W-1:0]  meas_val
);

  localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int INB_W = $clog2(LOCK_CNT + 1);
  localparam int TMR_W = 16;
  localparam logic [IDX_W-1:0] TOP = IDX_W'(CODE_W - 1);

  fsm_state_t        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [IDX_W-1:0]  bit_q, bit_d;
  logic [INB_W-1:0]  inb_q, inb_d;
  logic [CNT_W-1:0]  tgt_q, tgt_d;
  logic [CNT_W-1:0]  mval_q, mval_d;
  logic              done_q, done_d;
  logic              lock_q, lock_d;
  logic              sat_q, sat_d;
  logic              men_q, men_d;
  logic              mrst_q, mrst_d;

  logic              tmr_ld;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_done;

  logic [CNT_W:0]    lo_w, hi_w;
  logic [CNT_W-1:0]  lo, hi;

  assign lo_w = {1'b0, tgt_q} - (CNT_W + 1)'(TOL);
  assign hi_w = {1'b0, tgt_q} + (CNT_W + 1)'(TOL);
  assign lo   = lo_w[CNT_W] ? '0 : lo_w[CNT_W-1:0];
  assign hi   = hi_w[CNT_W] ? '1 : hi_w[CNT_W-1:0];

  win_timer #(.W(TMR_W)) u_tmr (
    .F_clk    (F_clk),
    .combReset(combReset),
    .ld_i     (tmr_ld),
    .val_i    (tmr_val),
    .done_o   (tmr_done)
  );

  // next state, code search/tracking and lock bookkeeping
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    bit_d   = bit_q;
    inb_d   = inb_q;
    tgt_d   = tgt_q;
    mval_d  = mval_q;
    done_d  = done_q;
    lock_d  = lock_q;
    sat_d   = sat_q;
    tmr_ld  = 1'b0;
    tmr_val = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          tgt_d   = target;
          code_d  = '0;
          code_d[CODE_W-1] = 1'b1;
          tmr_ld  = 1'b1;
          tmr_val = TMR_W'(SETTLE_CYC);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (tmr_done) state_d = MRST;
      end
      MRST: begin
        tmr_ld  = 1'b1;
        tmr_val = TMR_W'(WIN_CYC);
        state_d = MEASURE;
      end
      MEASURE: begin
        if (tmr_done) begin
          mval_d  = c_freq;
          state_d = done_q ? TRK_EVAL : SAR_EVAL;
        end
      end
      SAR_EVAL: begin
        if (mval_q > tgt_q) code_d[bit_q] = 1'b0;
        if (bit_q == '0) begin
          done_d  = 1'b1;
          state_d = TRK_EVAL;
        end else begin
          bit_d   = bit_q - 1'b1;
          code_d[bit_q - 1'b1] = 1'b1;
          tmr_ld  = 1'b1;
          tmr_val = TMR_W'(SETTLE_CYC);
          state_d = SETTLE;
        end
      end
      TRK_EVAL: begin
        if (mval_q > hi) begin
          if (code_q == '0) sat_d = 1'b1;
          else              code_d = code_q - 1'b1;
          inb_d  = '0;
          lock_d = 1'b0;
        end else if (mval_q < lo) begin
          if (&code_q) sat_d = 1'b1;
          else         code_d = code_q + 1'b1;
          inb_d  = '0;
          lock_d = 1'b0;
        end else begin
          if (inb_q < INB_W'(LOCK_CNT)) inb_d = inb_q + 1'b1;
          lock_d = (inb_d == INB_W'(LOCK_CNT));
        end
        if (code_d != code_q) begin
          tmr_ld  = 1'b1;
          tmr_val = TMR_W'(SETTLE_CYC);
          state_d = SETTLE;
        end else begin
          state_d = MRST;
        end
      end
      default: state_d = IDLE;
    endcase
    // dropping start abandons the current step, keeping code and count
    if (!start && state_q != IDLE) begin
      state_d = IDLE;
      code_d  = code_q;
      mval_d  = mval_q;
      tmr_ld  = 1'b1;
      tmr_val = '0;
    end
    if (state_d == IDLE) begin
      bit_d  = TOP;
      inb_d  = '0;
      done_d = 1'b0;
      lock_d = 1'b0;
      sat_d  = 1'b0;
    end
    men_d  = (state_d == MRST) || (state_d == MEASURE);
    mrst_d = (state_d == MRST);
  end

  // state and output registers
  always_ff @(posedge F_clk or posedge combReset) begin
    if (combReset) begin
      state_q <= IDLE;
      code_q  <= '0;
      bit_q   <= TOP;
      inb_q   <= '0;
      tgt_q   <= '0;
      mval_q  <= '0;
      done_q  <= 1'b0;
      lock_q  <= 1'b0;
      sat_q   <= 1'b0;
      men_q   <= 1'b0;
      mrst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      bit_q   <= bit_d;
      inb_q   <= inb_d;
      tgt_q   <= tgt_d;
      mval_q  <= mval_d;
      done_q  <= done_d;
      lock_q  <= lock_d;
      sat_q   <= sat_d;
      men_q   <= men_d;
      mrst_q  <= mrst_d;
    end
  end

  assign meas_en    = men_q;
  assign meas_reset = mrst_q;
  assign dco_code   = code_q;
  assign sar_done   = done_q;
  assign locked     = lock_q;
  assign sat        = sat_q;
  assign meas_val   = mval_q;

endmodule

// File: tb/tb_freq_lock_ctrl.sv
// Directed bench for freq_lock_ctrl with a linear counter model
// c_freq = mult * dco_code.
module tb_freq_lock_ctrl;

  logic        F_clk = 1'b0;
  logic        combReset;
  logic        start;
  logic [31:0] target;
  logic [31:0] c_freq;
  logic        meas_en, meas_reset;
  logic [7:0]  dco_code;
  logic        sar_done, locked, sat;
  logic [31:0] meas_val;

  logic [31:0] mult;
  int n_chk  = 0;
  int n_fail = 0;

  logic       log_en = 1'b0;
  int         nlog   = 0;
  logic [7:0] seq [8];
  int         nrst   = 0;

  always #5 F_clk = ~F_clk;

  assign c_freq = mult * {24'd0, dco_code};

  freq_lock_ctrl dut (
    .F_clk     (F_clk),
    .combReset (combReset),
    .start     (start),
    .target    (target),
    .c_freq    (c_freq),
    .meas_en   (meas_en),
    .meas_reset(meas_reset),
    .dco_code  (dco_code),
    .sar_done  (sar_done),
    .locked    (locked),
    .sat       (sat),
    .meas_val  (meas_val)
  );

  // record the code under test at every measurement reset pulse
  always @(negedge F_clk) begin
    if (meas_reset) nrst++;
    if (log_en && meas_reset && nlog < 8) begin
      seq[nlog] = dco_code;
      nlog++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge F_clk);
  endtask

  task automatic wait_done(input string tag, input int lim, output int c);
    c = 0;
    while (!sar_done && c < lim) begin
      @(negedge F_clk);
      c++;
    end
    check(tag, {31'd0, sar_done}, 1);
  endtask

  task automatic wait_lock(input string tag, input logic lv,
                           input int lim);
    int c = 0;
    while (locked !== lv && c < lim) begin
      @(negedge F_clk);
      c++;
    end
    check(tag, {31'd0, locked}, {31'd0, lv});
  endtask

  task automatic chk_rst(input string tag);
    check({tag, "_code"}, dco_code, 0);
    check({tag, "_men"}, meas_en, 0);
    check({tag, "_mrst"}, meas_reset, 0);
    check({tag, "_done"}, sar_done, 0);
    check({tag, "_lock"}, locked, 0);
    check({tag, "_sat"}, sat, 0);
    check({tag, "_mval"}, meas_val, 0);
  endtask

  initial begin
    int lat;
    logic [7:0] exp_seq [8];
    exp_seq = '{8'd128, 8'd64, 8'd96, 8'd112,
                8'd104, 8'd100, 8'd102, 8'd101};
    combReset = 1'b1;
    start     = 1'b0;
    target    = 32'd400;
    mult      = 32'd4;
    cyc(3);
    chk_rst("rst");
    combReset = 1'b0;
    cyc(2);

    // SAR acquisition against target 400
    log_en = 1'b1;
    start  = 1'b1;
    wait_done("sar_done", 1200, lat);
    check("sar_lat_ok", {31'd0, (lat >= 900 && lat <= 976)}, 1);
    log_en = 1'b0;
    check("sar_nlog", nlog, 8);
    for (int i = 0; i < 8; i++) check($sformatf("seq%0d", i), seq[i], exp_seq[i]);
    check("sar_final", dco_code, 100);

    // tracking in band -> lock
    wait_lock("lock1", 1'b1, 1000);
    check("lock1_code", dco_code, 100);
    check("lock1_mval", meas_val, 400);
    check("lock1_sat", sat, 0);

    // gain change: drop lock, walk down to 81
    mult = 32'd5;
    wait_lock("unlock", 1'b0, 400);
    check("unlock_code", dco_code, 99);
    wait_lock("lock2", 1'b1, 5000);
    check("lock2_code", dco_code, 81);
    check("lock2_mval", meas_val, 405);

    // unreachable target saturates at max code
    start = 1'b0;
    cyc(2);
    check("idle_done", sar_done, 0);
    check("idle_lock", locked, 0);
    check("idle_code", dco_code, 81);
    target = 32'd2000;
    mult   = 32'd4;
    start  = 1'b1;
    wait_done("sat_done", 1200, lat);
    check("sat_code0", dco_code, 255);
    cyc(300);
    check("sat_flag", sat, 1);
    check("sat_lock", locked, 0);
    check("sat_code", dco_code, 255);

    // asynchronous reset mid-measurement, then full re-acquire
    start  = 1'b0;
    cyc(2);
    target = 32'd400;
    start  = 1'b1;
    lat = 0;
    while (!(meas_en && !meas_reset) && lat < 100) begin
      @(negedge F_clk);
      lat++;
    end
    check("in_meas", {31'd0, meas_en}, 1);
    cyc(10);
    combReset = 1'b1;
    #1;
    chk_rst("arst");
    start = 1'b0;
    cyc(1);
    combReset = 1'b0;
    cyc(1);
    chk_rst("arst_hold");
    nlog   = 0;
    log_en = 1'b1;
    start  = 1'b1;
    wait_done("re_done", 1200, lat);
    log_en = 1'b0;
    check("re_first", seq[0], 128);
    check("re_final", dco_code, 100);

    // start dropped during SETTLE: no reset pulse, code held
    start = 1'b0;
    cyc(2);
    start = 1'b1;
    cyc(5);
    nrst  = 0;
    start = 1'b0;
    cyc(1);
    check("abort_men", meas_en, 0);
    check("abort_code", dco_code, 128);
    cyc(30);
    check("abort_nrst", nrst, 0);
    check("abort_code2", dco_code, 128);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
